// File: rtl/proc_fetch_seq_if.sv
// -----------------------------------------------------------------------------
// proc_fetch_seq_if
//   Bus bundle between the instruction sequencer, its synchronous program ROM
//   and the 9-bit processor core.
//
//   mem_addr   ROM address (sequencer -> ROM)
//   mem_rdata  ROM data, valid one cycle after mem_addr (ROM -> sequencer)
//   proc_din   processor DIN (sequencer -> processor)
//   proc_run   processor Run, one-cycle pulse (sequencer -> processor)
//   proc_done  processor Done (processor -> sequencer)
//
//   master: the sequencer side.  slave: the ROM/processor side.
// -----------------------------------------------------------------------------
interface proc_fetch_seq_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 9
) ();
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] proc_din;
    logic              proc_run;
    logic              proc_done;

    modport master (
        output mem_addr, proc_din, proc_run,
        input  mem_rdata, proc_done
    );

    modport slave (
        input  mem_addr, proc_din, proc_run,
        output mem_rdata, proc_done
    );
endinterface

// File: rtl/proc_fetch_seq.sv
// -----------------------------------------------------------------------------
// proc_fetch_seq
//   Instruction sequencer for the 9-bit mv/mvi/add/sub processor. Fetches a
//   word from the program ROM, issues it on proc_din with a one-cycle proc_run
//   pulse, supplies the mvi immediate while the core executes, waits for
//   proc_done and advances the PC. Supports free-run, single-step, HALT opcodes
//   (1xx) and a watchdog on proc_done.
//
//   Clock        rising-edge clock
//   Resetn       synchronous active-low reset
//   start        begin execution at start_addr (accepted in IDLE/HALT/ERR)
//   step         1 = return to IDLE after each retired instruction
//   start_addr   PC loaded on an accepted start
//   bus          ROM + processor signals (master side)
//   busy         1 in any state except IDLE/HALT/ERR
//   halted       1 in HALT
//   err          1 in ERR (watchdog expired)
//   pc           address of the current instruction
//   instr_count  retired instructions, wraps modulo 2**16
// -----------------------------------------------------------------------------
module proc_fetch_seq #(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 9,
    parameter int TIMEOUT = 15
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              start,
    input  logic              step,
    input  logic [ADDR_W-1:0] start_addr,
    proc_fetch_seq_if.master  bus,
    output logic              busy,
    output logic              halted,
    output logic              err,
    output logic [ADDR_W-1:0] pc,
    output logic [15:0]       instr_count
);

    localparam int WDOG_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_IMM, S_ISSUE, S_WAIT, S_HALT, S_ERR
    } state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] pc_next, mem_addr_q, mem_addr_next, pc_adv;
    logic [DATA_W-1:0] instr, instr_next, imm, imm_next, din_q;
    logic [WDOG_W-1:0] wdog, wdog_next;
    logic [15:0]       count_next;
    logic [2:0]        rdata_op;
    logic              is_mvi;

    assign rdata_op     = bus.mem_rdata[DATA_W-1 -: 3];
    assign is_mvi       = (instr[DATA_W-1 -: 3] == 3'b001);
    assign pc_adv       = pc + (is_mvi ? ADDR_W'(2) : ADDR_W'(1));
    assign bus.mem_addr = mem_addr_q;

    // Next-state and datapath update.
    always_comb begin
        // NOTE: every signal gets a default before the case, so no path can
        // leave one unassigned and infer a latch.
        state_next    = state;
        pc_next       = pc;
        mem_addr_next = mem_addr_q;
        instr_next    = instr;
        imm_next      = imm;
        wdog_next     = wdog;
        count_next    = instr_count;

        unique case (state)
            S_IDLE, S_HALT, S_ERR: begin
                if (start) begin
                    pc_next       = start_addr;
                    mem_addr_next = start_addr;
                    state_next    = S_FETCH;
                end
            end
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                instr_next = bus.mem_rdata;
                if (rdata_op[2]) begin
                    state_next = S_HALT;
                end else if (rdata_op == 3'b001) begin
                    mem_addr_next = pc + ADDR_W'(1);
                    state_next    = S_IMM;
                end else begin
                    state_next = S_ISSUE;
                end
            end
            S_IMM: state_next = S_ISSUE;
            S_ISSUE: begin
                // The immediate address goes out at the end of DECODE, so with
                // one cycle of ROM latency its data is on mem_rdata during ISSUE;
                // it is first needed on proc_din in WAIT.
                if (is_mvi) imm_next = bus.mem_rdata;
                wdog_next  = '0;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (bus.proc_done) begin
                    pc_next       = pc_adv;
                    mem_addr_next = pc_adv;
                    count_next    = instr_count + 16'd1;
                    state_next    = step ? S_IDLE : S_FETCH;
                end else if (wdog == WDOG_W'(TIMEOUT - 1)) begin
                    state_next = S_ERR;
                end else begin
                    wdog_next = wdog + WDOG_W'(1);
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs decoded from state; proc_din falls back to its last driven value.
    always_comb begin
        bus.proc_run = (state == S_ISSUE);
        unique case (state)
            S_ISSUE: bus.proc_din = instr;
            S_WAIT:  bus.proc_din = is_mvi ? imm : instr;
            default: bus.proc_din = din_q;
        endcase
        busy   = !(state inside {S_IDLE, S_HALT, S_ERR});
        halted = (state == S_HALT);
        err    = (state == S_ERR);
    end

    // NOTE: Resetn is tested inside the clocked block and is not in the
    // sensitivity list, so reset takes effect only at a rising edge.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge Clock) begin
        // NOTE: non-blocking assignments make every register here sample the
        // pre-edge values, independent of statement order.
        if (!Resetn) begin
            pc          <= '0;
            mem_addr_q  <= '0;
            instr       <= '0;
            imm         <= '0;
            wdog        <= '0;
            instr_count <= '0;
            din_q       <= '0;
        end else begin
            pc          <= pc_next;
            mem_addr_q  <= mem_addr_next;
            instr       <= instr_next;
            imm         <= imm_next;
            wdog        <= wdog_next;
            instr_count <= count_next;
            din_q       <= bus.proc_din;
        end
    end

endmodule
